// File: rtl/axi_pkg.sv
// Shared AXI read-side types and widths for axi_rd_slave and its address generator.
package axi_pkg;

    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_RESP_W  = 2;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_e;

    // Encoding 3 is reserved by AXI and answered with SLVERR.
    localparam logic [1:0] BURST_RSVD = 2'd3;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } rd_state_e;

    function automatic logic wrap_len_ok(input logic [AXI_LEN_W-1:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_rd_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
module axi_rd_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [AXI_SIZE_W-1:0]  size,
    input  logic [AXI_LEN_W-1:0]   len,
    input  logic [AXI_BURST_W-1:0] burst,
    output logic [ADDR_WIDTH-1:0]  next_addr
);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    always_comb begin
        step      = ADDR_WIDTH'(1) << size;
        incr_addr = addr + step;
        // Window is (len+1) beats of 2^size bytes; only bits inside it move.
        wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            BURST_INCR: next_addr = incr_addr;
            BURST_WRAP: next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:    next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_rd_slave.sv
// AXI4 read-only slave backed by a word array with a registered backdoor write port.
// Define AXI_RD_DECERR_EN to answer out-of-range word indices with DECERR instead of wrapping.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | arready high, waiting for an AR handshake
// ST_BURST | returning beats of the captured burst, rvalid high
module axi_rd_slave
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                         sig_clock,
    input  logic                         sig_reset,
    input  logic [ID_WIDTH-1:0]          arid,
    input  logic [ADDR_WIDTH-1:0]        araddr,
    input  logic [7:0]                   arlen,
    input  logic [2:0]                   arsize,
    input  logic [1:0]                   arburst,
    input  logic                         arvalid,
    output logic                         arready,
    output logic [ID_WIDTH-1:0]          rid,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic [1:0]                   rresp,
    output logic                         rlast,
    output logic                         rvalid,
    input  logic                         rready,
    input  logic                         mem_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0]        mem_wdata
);

    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W      = $clog2(MEM_DEPTH);

    rd_state_e              state;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [ADDR_WIDTH-1:0]  addr_nxt;
    logic [AXI_LEN_W-1:0]   len_q;
    logic [AXI_LEN_W-1:0]   cnt_q;
    logic [AXI_SIZE_W-1:0]  size_q;
    logic [AXI_BURST_W-1:0] burst_q;
    logic                   slverr_q;
    logic                   ar_bad;
    logic                   beat_done;
    logic [IDX_W-1:0]       mem_idx;
    logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

    assign beat_done = rvalid && rready;
    assign mem_idx   = addr_q[BYTE_SHIFT +: IDX_W];

    // Error class is fixed by the AR fields, so decide it once at capture.
    assign ar_bad = (arburst == BURST_RSVD) ||
                    (arsize > AXI_SIZE_W'(BYTE_SHIFT)) ||
                    ((arburst == BURST_WRAP) && !wrap_len_ok(arlen));

    axi_rd_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (addr_nxt)
    );

    always_ff @(posedge sig_clock or posedge sig_reset) begin
        if (sig_reset) begin
            state    <= ST_IDLE;
            arready  <= 1'b1;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            rid      <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            slverr_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arvalid) begin
                        state    <= ST_BURST;
                        arready  <= 1'b0;
                        rvalid   <= 1'b1;
                        rid      <= arid;
                        addr_q   <= araddr;
                        len_q    <= arlen;
                        size_q   <= arsize;
                        burst_q  <= arburst;
                        slverr_q <= ar_bad;
                        cnt_q    <= '0;
                        rlast    <= (arlen == '0);
                    end
                end
                ST_BURST: begin
                    if (beat_done) begin
                        if (rlast) begin
                            state   <= ST_IDLE;
                            arready <= 1'b1;
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                        end else begin
                            cnt_q  <= cnt_q + AXI_LEN_W'(1);
                            addr_q <= addr_nxt;
                            rlast  <= ((cnt_q + AXI_LEN_W'(1)) == len_q);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sig_clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

`ifdef AXI_RD_DECERR_EN
    logic dec_hit;
    assign dec_hit = (addr_q >> (BYTE_SHIFT + IDX_W)) != '0;
`endif

    always_comb begin
        rresp = RESP_OKAY;
        if (rvalid) begin
            if (slverr_q) begin
                rresp = RESP_SLVERR;
`ifdef AXI_RD_DECERR_EN
            end else if (dec_hit) begin
                rresp = RESP_DECERR;
`endif
            end
        end
    end

    // Data follows the live array so a backdoor write shows up during a stall.
    assign rdata = (rvalid && (rresp == RESP_OKAY)) ? mem[mem_idx] : '0;

endmodule

// File: tb/tb_axi_rd_slave.sv
// Directed bench for axi_rd_slave: vector table of bursts plus stall, reset and backdoor sequences.
module tb_axi_rd_slave;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int MD = 256;

    typedef struct {
        logic [IW-1:0]   id;
        logic [AW-1:0]   addr;
        logic [7:0]      len;
        logic [2:0]      size;
        logic [1:0]      burst;
        logic [1:0]      resp;
        logic [3:0][7:0] idx;
    } vec_t;

    logic          sig_clock = 1'b0;
    logic          sig_reset = 1'b0;
    logic [IW-1:0] arid = '0;
    logic [AW-1:0] araddr = '0;
    logic [7:0]    arlen = '0;
    logic [2:0]    arsize = '0;
    logic [1:0]    arburst = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready = 1'b0;
    logic          mem_we = 1'b0;
    logic [7:0]    mem_waddr = '0;
    logic [DW-1:0] mem_wdata = '0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_mem [MD];
    vec_t vecs [9];

    axi_rd_slave #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .ID_WIDTH   (IW),
        .MEM_DEPTH  (MD)
    ) dut (
        .sig_clock (sig_clock),
        .sig_reset (sig_reset),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (arready),
        .rid       (rid),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata)
    );

    always #5 sig_clock = ~sig_clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                                input logic [7:0] len, input logic [2:0] size,
                                input logic [1:0] burst, input logic [1:0] resp,
                                input logic [7:0] i0, input logic [7:0] i1,
                                input logic [7:0] i2, input logic [7:0] i3);
        vec_t v;
        v.id = id; v.addr = addr; v.len = len; v.size = size;
        v.burst = burst; v.resp = resp; v.idx = {i3, i2, i1, i0};
        return v;
    endfunction

    task automatic bd_write(input logic [7:0] idx, input logic [DW-1:0] d);
        @(negedge sig_clock);
        mem_we = 1'b1; mem_waddr = idx; mem_wdata = d;
        @(negedge sig_clock);
        mem_we = 1'b0;
        exp_mem[idx] = d;
    endtask

    task automatic start_ar(input vec_t v, input string tag);
        @(negedge sig_clock);
        arid = v.id; araddr = v.addr; arlen = v.len; arsize = v.size; arburst = v.burst;
        arvalid = 1'b1;
        chk({tag, "_arready"}, 64'(arready), 64'd1);
        @(posedge sig_clock);
        #1 arvalid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [DW-1:0] ed;
        rready = 1'b1;
        start_ar(v, tag);
        for (int b = 0; b <= int'(v.len); b++) begin
            @(negedge sig_clock);
            ed = (v.resp == 2'd0) ? exp_mem[v.idx[b]] : '0;
            chk($sformatf("%s_b%0d_rvalid", tag, b), 64'(rvalid), 64'd1);
            chk($sformatf("%s_b%0d_rid", tag, b), 64'(rid), 64'(v.id));
            chk($sformatf("%s_b%0d_rdata", tag, b), 64'(rdata), 64'(ed));
            chk($sformatf("%s_b%0d_rresp", tag, b), 64'(rresp), 64'(v.resp));
            chk($sformatf("%s_b%0d_rlast", tag, b), 64'(rlast), 64'(b == int'(v.len)));
        end
        @(negedge sig_clock);
        chk({tag, "_end_rvalid"}, 64'(rvalid), 64'd0);
        chk({tag, "_end_arready"}, 64'(arready), 64'd1);
    endtask

    initial begin
        vec_t v;

        #2 sig_reset = 1'b1;
        #1;
        chk("rst_arready", 64'(arready), 64'd1);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rlast", 64'(rlast), 64'd0);
        chk("rst_rresp", 64'(rresp), 64'd0);
        chk("rst_rid", 64'(rid), 64'd0);
        repeat (2) @(negedge sig_clock);
        sig_reset = 1'b0;

        for (int i = 0; i < MD; i++) exp_mem[i] = '0;
        for (int i = 0; i < 16; i++) bd_write(8'(i), 32'hD0D0_0000 + 32'(i) * 32'h0101);

        vecs[0] = mk(4'h1, 32'h10, 8'd3, 3'd2, 2'd1, 2'd0, 8'd4, 8'd5, 8'd6, 8'd7);
        vecs[1] = mk(4'h2, 32'h18, 8'd3, 3'd2, 2'd2, 2'd0, 8'd6, 8'd7, 8'd4, 8'd5);
        vecs[2] = mk(4'hF, 32'h00, 8'd0, 3'd2, 2'd1, 2'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        vecs[3] = mk(4'h3, 32'h10, 8'd1, 3'd2, 2'd3, 2'd2, 8'd0, 8'd0, 8'd0, 8'd0);
        vecs[4] = mk(4'h4, 32'h10, 8'd1, 3'd3, 2'd1, 2'd2, 8'd0, 8'd0, 8'd0, 8'd0);
        vecs[5] = mk(4'h5, 32'h10, 8'd2, 3'd2, 2'd2, 2'd2, 8'd0, 8'd0, 8'd0, 8'd0);
`ifdef AXI_RD_DECERR_EN
        vecs[6] = mk(4'h7, 32'h400, 8'd0, 3'd2, 2'd1, 2'd3, 8'd0, 8'd0, 8'd0, 8'd0);
`else
        vecs[6] = mk(4'h7, 32'h400, 8'd0, 3'd2, 2'd1, 2'd0, 8'd0, 8'd0, 8'd0, 8'd0);
`endif
        vecs[7] = mk(4'h8, 32'h04, 8'd1, 3'd2, 2'd2, 2'd0, 8'd1, 8'd0, 8'd0, 8'd0);
        vecs[8] = mk(4'h9, 32'h10, 8'd3, 3'd1, 2'd1, 2'd0, 8'd4, 8'd4, 8'd5, 8'd5);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // FIXED burst with a three-cycle stall on beat 1 and a stray AR during the burst
        v = mk(4'h6, 32'h08, 8'd2, 3'd2, 2'd0, 2'd0, 8'd2, 8'd2, 8'd2, 8'd0);
        rready = 1'b1;
        start_ar(v, "fix");
        @(negedge sig_clock);
        chk("fix_b0_rdata", 64'(rdata), 64'(exp_mem[2]));
        chk("fix_b0_rlast", 64'(rlast), 64'd0);
        @(negedge sig_clock);
        rready = 1'b0;
        arid = 4'hA; araddr = 32'h10; arlen = 8'd0; arburst = 2'd1; arvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge sig_clock);
            chk($sformatf("fix_stall%0d_rvalid", k), 64'(rvalid), 64'd1);
            chk($sformatf("fix_stall%0d_rdata", k), 64'(rdata), 64'(exp_mem[2]));
            chk($sformatf("fix_stall%0d_rlast", k), 64'(rlast), 64'd0);
            chk($sformatf("fix_stall%0d_rresp", k), 64'(rresp), 64'd0);
            chk($sformatf("fix_stall%0d_rid", k), 64'(rid), 64'h6);
            chk($sformatf("fix_stall%0d_arready", k), 64'(arready), 64'd0);
        end
        rready = 1'b1;
        arvalid = 1'b0;
        @(negedge sig_clock);
        chk("fix_b2_rdata", 64'(rdata), 64'(exp_mem[2]));
        chk("fix_b2_rlast", 64'(rlast), 64'd1);
        chk("fix_b2_rid", 64'(rid), 64'h6);
        @(negedge sig_clock);
        chk("fix_end_rvalid", 64'(rvalid), 64'd0);
        @(negedge sig_clock);
        chk("fix_no_capture", 64'(rvalid), 64'd0);

        // Reset in the middle of a long INCR burst
        v = mk(4'h3, 32'h00, 8'd7, 3'd2, 2'd1, 2'd0, 8'd0, 8'd1, 8'd2, 8'd3);
        rready = 1'b1;
        start_ar(v, "rst");
        @(negedge sig_clock);
        chk("rst_b0_rdata", 64'(rdata), 64'(exp_mem[0]));
        @(negedge sig_clock);
        chk("rst_b1_rdata", 64'(rdata), 64'(exp_mem[1]));
        chk("rst_b1_rid", 64'(rid), 64'h3);
        sig_reset = 1'b1;
        #1;
        chk("midrst_rvalid", 64'(rvalid), 64'd0);
        chk("midrst_arready", 64'(arready), 64'd1);
        chk("midrst_rlast", 64'(rlast), 64'd0);
        chk("midrst_rid", 64'(rid), 64'd0);
        chk("midrst_rresp", 64'(rresp), 64'd0);
        @(negedge sig_clock);
        sig_reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge sig_clock);
            chk($sformatf("postrst%0d_rvalid", k), 64'(rvalid), 64'd0);
        end
        run_vec(mk(4'h5, 32'h10, 8'd0, 3'd2, 2'd1, 2'd0, 8'd4, 8'd0, 8'd0, 8'd0), "post_rst");

        // Backdoor write lands while the beat is stalled
        v = mk(4'h2, 32'h24, 8'd0, 3'd2, 2'd0, 2'd0, 8'd9, 8'd0, 8'd0, 8'd0);
        rready = 1'b0;
        start_ar(v, "bd");
        @(negedge sig_clock);
        chk("bd_old_rdata", 64'(rdata), 64'(exp_mem[9]));
        mem_we = 1'b1; mem_waddr = 8'd9; mem_wdata = 32'hCAFE_F00D;
        @(negedge sig_clock);
        mem_we = 1'b0;
        exp_mem[9] = 32'hCAFE_F00D;
        chk("bd_new_rdata", 64'(rdata), 64'(exp_mem[9]));
        chk("bd_rlast", 64'(rlast), 64'd1);
        rready = 1'b1;
        @(negedge sig_clock);
        chk("bd_end_rvalid", 64'(rvalid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
